// File: rtl/ladybird_fetch_seq.sv
// Fetch sequencer: issues sequential PCs to the IFU and buffers {inst, pc} returns for decode.
// Define LADYBIRD_FETCH_PERF_EN to add the perf_fetch / perf_drop counters.
package ladybird_config;
  localparam int XLEN = 32;
endpackage

module ladybird_fetch_seq #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ladybird_config::XLEN-1:0] redirect_pc,
  input  logic                             redirect_valid,
  output logic [ladybird_config::XLEN-1:0] pc,
  output logic                             pc_valid,
  input  logic                             pc_ready,
  input  logic [ladybird_config::XLEN-1:0] f_inst,
  input  logic [ladybird_config::XLEN-1:0] f_inst_pc,
  input  logic                             f_inst_valid,
  output logic                             f_inst_ready,
  output logic [ladybird_config::XLEN-1:0] d_inst,
  output logic [ladybird_config::XLEN-1:0] d_pc,
  output logic                             d_valid,
  input  logic                             d_ready
`ifdef LADYBIRD_FETCH_PERF_EN
  ,
  output logic [31:0]                      perf_fetch,
  output logic [31:0]                      perf_drop
`endif
);
  localparam int XLEN = ladybird_config::XLEN;
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  logic [XLEN-1:0] pc_q;
  logic [CW-1:0]   count_q, outstanding_q, drop_q;
  logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [XLEN-1:0] inst_mem [FIFO_DEPTH];
  logic [XLEN-1:0] pc_mem   [FIFO_DEPTH];
  logic [CW:0]     credit_used;
  logic            fire, resp, dec, discard, push, pop;

  // Requests are only issued when a FIFO slot is guaranteed for the response.
  assign credit_used  = {1'b0, count_q} + {1'b0, outstanding_q};
  assign pc           = pc_q;
  assign pc_valid     = ~rst & ~redirect_valid & (credit_used < DEPTH_C);
  assign f_inst_ready = 1'b1;
  assign d_valid      = (count_q != '0);
  assign d_inst       = inst_mem[rd_ptr_q];
  assign d_pc         = pc_mem[rd_ptr_q];

  assign fire    = pc_valid & pc_ready;
  assign resp    = f_inst_valid;
  // Saturate so a stray response after a mid-run reset cannot wrap the counter.
  assign dec     = resp & (outstanding_q != '0);
  assign discard = resp & (redirect_valid | (drop_q != '0));
  assign push    = resp & ~discard;
  assign pop     = d_valid & d_ready & ~redirect_valid;

  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr_q] <= f_inst;
      pc_mem[wr_ptr_q]   <= f_inst_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else if (redirect_valid) begin
      pc_q          <= redirect_pc;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      outstanding_q <= outstanding_q - CW'(dec);
      drop_q        <= outstanding_q - CW'(dec);
    end else begin
      if (fire) pc_q <= pc_q + XLEN'(4);
      outstanding_q <= outstanding_q + CW'(fire) - CW'(dec);
      if (discard) drop_q <= drop_q - CW'(1);
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  assert property (@(posedge clk) disable iff (rst) drop_q <= outstanding_q);

`ifdef LADYBIRD_FETCH_PERF_EN
  logic [CW-1:0] drop_inc;
  logic [32:0]   drop_sum;

  always_comb begin
    drop_inc = CW'(discard);
    if (redirect_valid) drop_inc = count_q + CW'(discard);
  end

  assign drop_sum = {1'b0, perf_drop} + 33'(drop_inc);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch <= '0;
      perf_drop  <= '0;
    end else begin
      if (fire && (perf_fetch != '1)) perf_fetch <= perf_fetch + 32'd1;
      perf_drop <= drop_sum[32] ? '1 : drop_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_ladybird_fetch_seq.sv
// Scoreboard bench for ladybird_fetch_seq with a small in-order IFU model of configurable latency.
module tb_ladybird_fetch_seq;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] KEY    = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] redirect_pc;
  logic        redirect_valid;
  logic [31:0] pc;
  logic        pc_valid;
  logic        pc_ready;
  logic [31:0] f_inst;
  logic [31:0] f_inst_pc;
  logic        f_inst_valid;
  logic        f_inst_ready;
  logic [31:0] d_inst;
  logic [31:0] d_pc;
  logic        d_valid;
  logic        d_ready;
`ifdef LADYBIRD_FETCH_PERF_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_drop;
`endif

  ladybird_fetch_seq #(.RESET_PC(RST_PC), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .redirect_pc(redirect_pc), .redirect_valid(redirect_valid),
    .pc(pc), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .f_inst(f_inst), .f_inst_pc(f_inst_pc), .f_inst_valid(f_inst_valid),
    .f_inst_ready(f_inst_ready),
    .d_inst(d_inst), .d_pc(d_pc), .d_valid(d_valid), .d_ready(d_ready)
`ifdef LADYBIRD_FETCH_PERF_EN
    , .perf_fetch(perf_fetch), .perf_drop(perf_drop)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    int          due;
  } req_t;

  req_t        ifu_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] exp_pc;
  int n_tests = 0, n_fail = 0, cyc = 0, n_hs = 0, ifu_lat = 1;
  logic s_fv, s_dv;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive IFU response, sample at the falling edge, update model, advance.
  task automatic tick();
    logic        hs, pop;
    logic [63:0] e;
    if (ifu_q.size() > 0 && ifu_q[0].due <= cyc) begin
      f_inst_valid = 1'b1;
      f_inst_pc    = ifu_q[0].pc;
      f_inst       = ifu_q[0].pc ^ KEY;
    end else begin
      f_inst_valid = 1'b0;
      f_inst_pc    = '0;
      f_inst       = '0;
    end
    #4;
    s_fv = f_inst_valid;
    s_dv = d_valid;
    hs   = pc_valid & pc_ready;
    pop  = d_valid & d_ready & ~redirect_valid & ~rst;
    if (rst) chk("rst_pc_valid", 32'(pc_valid), 32'd0);
    if (redirect_valid) chk("redir_no_issue", 32'(pc_valid), 32'd0);
    if (pop) begin
      chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("d_pc", d_pc, e[31:0]);
        chk("d_inst", d_inst, e[63:32]);
      end
    end
    if (hs) begin
      chk("fetch_pc", pc, exp_pc);
      ifu_q.push_back('{pc: pc, due: cyc + ifu_lat});
      exp_q.push_back({exp_pc ^ KEY, exp_pc});
      exp_pc = exp_pc + 32'd4;
      n_hs++;
    end
    if (f_inst_valid) void'(ifu_q.pop_front());
    if (rst) begin
      exp_q.delete();
      exp_pc = RST_PC;
    end else if (redirect_valid) begin
      exp_q.delete();
      exp_pc = redirect_pc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic redirect(input logic [31:0] a);
    redirect_valid = 1'b1;
    redirect_pc    = a;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int g;
    rst = 1'b1; pc_ready = 1'b0; d_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    f_inst_valid = 1'b0; f_inst = '0; f_inst_pc = '0;
    exp_pc = RST_PC;
    @(posedge clk);
    #1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_pc", pc, RST_PC);
    chk("rst_d_valid", 32'(d_valid), 32'd0);
    chk("f_inst_ready", 32'(f_inst_ready), 32'd1);

    // Sequential fetch, response pushed with one cycle of latency to d_valid
    pc_ready = 1'b1; d_ready = 1'b1; ifu_lat = 1;
    tick();
    tick();
    chk("lat_d_valid", 32'(d_valid), 32'd1);
    chk("lat_d_pc", d_pc, 32'h0000_0100);
    repeat (10) tick();

    // Credit limit with decode stalled
    d_ready = 1'b0;
    redirect(32'h0000_0300);
    n_hs = 0;
    repeat (10) tick();
    chk("credit_hs", 32'(n_hs), 32'd4);
    chk("credit_stall", 32'(pc_valid), 32'd0);
    d_ready = 1'b1;
    tick();
    d_ready = 1'b0;
    n_hs = 0;
    repeat (8) tick();
    chk("refill_hs", 32'(n_hs), 32'd1);

    // Flush with two buffered and two in flight
    ifu_lat = 3;
    redirect(32'h0000_0200);
    g = 0;
    while (!(ifu_q.size() == 2 && exp_q.size() == 4) && g < 40) begin
      tick();
      g++;
    end
    chk("flush_setup", 32'(ifu_q.size() == 2 && exp_q.size() == 4), 32'd1);
    redirect(32'h0000_0400);
    chk("flush_d_valid", 32'(d_valid), 32'd0);
    d_ready = 1'b1; ifu_lat = 1;
    g = 0;
    while (!d_valid && g < 20) begin
      tick();
      g++;
    end
    chk("flush_wait", 32'(d_valid), 32'd1);
    chk("flush_first_d_pc", d_pc, 32'h0000_0400);

    // Redirect coinciding with a response and a pop
    repeat (6) tick();
    redirect(32'h0000_0600);
    chk("coinc_resp", 32'(s_fv), 32'd1);
    chk("coinc_pop", 32'(s_dv), 32'd1);
    chk("coinc_pc", pc, 32'h0000_0600);
    chk("coinc_d_valid", 32'(d_valid), 32'd0);
    repeat (6) tick();

    // PC wrap
    redirect(32'hFFFF_FFFC);
    tick();
    chk("wrap_pc", pc, 32'h0000_0000);
    repeat (4) tick();

    pc_ready = 1'b0;
    repeat (10) tick();
    chk("drain_sb", 32'(exp_q.size()), 32'd0);
    chk("drain_d_valid", 32'(d_valid), 32'd0);

`ifdef LADYBIRD_FETCH_PERF_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("perf_rst", perf_fetch | perf_drop, 32'd0);
    n_hs = 0; ifu_lat = 1; d_ready = 1'b1; pc_ready = 1'b1;
    g = 0;
    while (n_hs < 7 && g < 40) begin
      tick();
      g++;
    end
    pc_ready = 1'b0;
    repeat (5) tick();
    ifu_lat = 20; pc_ready = 1'b1;
    g = 0;
    while (n_hs < 10 && g < 40) begin
      tick();
      g++;
    end
    pc_ready = 1'b0;
    redirect(32'h0000_0800);
    g = 0;
    while (ifu_q.size() != 0 && g < 40) begin
      tick();
      g++;
    end
    tick();
    chk("perf_fetch", perf_fetch, 32'd10);
    chk("perf_drop", perf_drop, 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
